// File: rtl/tl_phase_scheduler.sv
// Timed six-phase intersection scheduler. Main street rests in green, side street is served on demand,
// and crosswalk requests are latched and answered with a walk interval at the start of the next compatible green.
module tl_phase_scheduler #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 5,
  parameter int CW        = 6
) (
  input  logic       clk_62,
  input  logic       rst_62,
  input  logic       tick_62,
  input  logic       i1_62,
  input  logic       i2_62,
  input  logic       b1_62,
  input  logic       b2_62,
  input  logic       b3_62,
  input  logic       b4_62,
  output logic       r1_62,
  output logic       y1_62,
  output logic       g1_62,
  output logic       r2_62,
  output logic       y2_62,
  output logic       g2_62,
  output logic       w1_62,
  output logic       w2_62,
  output logic       w3_62,
  output logic       w4_62,
  output logic [2:0] phase_62
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  localparam logic [CW-1:0] MING_M1 = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAXG_M1 = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_M1   = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] WALK_T  = CW'(WALK);
  localparam logic [CW-1:0] TMAX    = {CW{1'b1}};

  state_t        state, state_nxt;
  logic [CW-1:0] timer;
  logic          side_req, ns_ped, ew_ped;
  logic          walk_ns, walk_ew;
  logic          enter_sg, enter_mg;

  // Main is the rest phase, so the main-street sensor never changes the sequence.
  logic unused_main_sensor;
  assign unused_main_sensor = i1_62;

  always_comb begin
    state_nxt = state;
    r1_62 = 1'b0;
    y1_62 = 1'b0;
    g1_62 = 1'b0;
    r2_62 = 1'b0;
    y2_62 = 1'b0;
    g2_62 = 1'b0;
    case (state)
      MG: begin
        g1_62 = 1'b1;
        r2_62 = 1'b1;
        if (tick_62 && timer >= MING_M1 && (side_req || ns_ped || i2_62)) state_nxt = MY;
      end
      MY: begin
        y1_62 = 1'b1;
        r2_62 = 1'b1;
        if (tick_62 && timer == YEL_M1) state_nxt = AR1;
      end
      AR1: begin
        r1_62 = 1'b1;
        r2_62 = 1'b1;
        if (tick_62 && timer == AR_M1) state_nxt = SG;
      end
      SG: begin
        r1_62 = 1'b1;
        g2_62 = 1'b1;
        if (tick_62 && timer >= MING_M1 && (!i2_62 || timer >= MAXG_M1)) state_nxt = SY;
      end
      SY: begin
        r1_62 = 1'b1;
        y2_62 = 1'b1;
        if (tick_62 && timer == YEL_M1) state_nxt = AR2;
      end
      AR2: begin
        r1_62 = 1'b1;
        r2_62 = 1'b1;
        if (tick_62 && timer == AR_M1) state_nxt = MG;
      end
      default: begin
        r1_62 = 1'b1;
        r2_62 = 1'b1;
        state_nxt = AR2;
      end
    endcase
  end

  assign enter_sg = (state_nxt == SG) && (state != SG);
  assign enter_mg = (state_nxt == MG) && (state != MG);

  // Request latches: a new request arriving on the clearing edge stays latched for the next service.
  always_ff @(posedge clk_62 or posedge rst_62) begin
    if (rst_62) begin
      state    <= MG;
      timer    <= '0;
      side_req <= 1'b0;
      ns_ped   <= 1'b0;
      ew_ped   <= 1'b0;
      walk_ns  <= 1'b0;
      walk_ew  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) timer <= '0;
      else if (tick_62 && timer != TMAX) timer <= timer + 1'b1;
      side_req <= (side_req && !enter_sg) || i2_62;
      ns_ped   <= (ns_ped && !enter_sg) || b2_62 || b4_62;
      ew_ped   <= (ew_ped && !enter_mg) || b1_62 || b3_62;
      if (enter_sg) walk_ns <= ns_ped;
      if (enter_mg) walk_ew <= ew_ped;
    end
  end

  assign w1_62 = walk_ns && (state == SG) && (timer < WALK_T);
  assign w3_62 = w1_62;
  assign w2_62 = walk_ew && (state == MG) && (timer < WALK_T);
  assign w4_62 = w2_62;
  assign phase_62 = state;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Directed bench for tl_phase_scheduler: cycle-by-cycle vector table plus idle, async-reset sequences.
module tb_tl_phase_scheduler;

  logic       clk_62 = 1'b0;
  logic       rst_62, tick_62, i1_62, i2_62, b1_62, b2_62, b3_62, b4_62;
  logic       r1_62, y1_62, g1_62, r2_62, y2_62, g2_62;
  logic       w1_62, w2_62, w3_62, w4_62;
  logic [2:0] phase_62;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       i2;
    logic [3:0] b;
    logic [2:0] ph;
    logic       wns;
    logic       wew;
  } vec_t;

  vec_t        tbl[$];
  logic [12:0] exp_q[$];

  tl_phase_scheduler #(
    .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW(2), .ALL_RED(1), .WALK(2), .CW(6)
  ) dut (
    .clk_62(clk_62), .rst_62(rst_62), .tick_62(tick_62),
    .i1_62(i1_62), .i2_62(i2_62),
    .b1_62(b1_62), .b2_62(b2_62), .b3_62(b3_62), .b4_62(b4_62),
    .r1_62(r1_62), .y1_62(y1_62), .g1_62(g1_62),
    .r2_62(r2_62), .y2_62(y2_62), .g2_62(g2_62),
    .w1_62(w1_62), .w2_62(w2_62), .w3_62(w3_62), .w4_62(w4_62),
    .phase_62(phase_62)
  );

  // clock / watchdog
  always #5 clk_62 = ~clk_62;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // lamp pattern {r1,y1,g1,r2,y2,g2} for each phase
  function automatic logic [5:0] lamps_for(input logic [2:0] ph);
    case (ph)
      3'd0:    return 6'b001_100;
      3'd1:    return 6'b010_100;
      3'd3:    return 6'b100_001;
      3'd4:    return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  function automatic logic [12:0] exp_word(input logic [2:0] ph, input logic wns, input logic wew);
    return {ph, lamps_for(ph), wns, wew, wns, wew};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [12:0] exp);
    check({tag, " phase"}, 13'(phase_62), 13'(exp[12:10]));
    check({tag, " lamps"}, 13'({r1_62, y1_62, g1_62, r2_62, y2_62, g2_62}), 13'(exp[9:4]));
    check({tag, " walks"}, 13'({w1_62, w2_62, w3_62, w4_62}), 13'(exp[3:0]));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_62);
    #1;
  endtask

  task automatic add(input logic i2, input logic [3:0] b, input logic [2:0] ph,
                     input logic wns, input logic wew, input int n);
    vec_t v;
    v.i2 = i2; v.b = b; v.ph = ph; v.wns = wns; v.wew = wew;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic build_table();
    // side call from a 1-cycle car pulse: SG held to min green
    add(1, 4'b0000, 1, 0, 0, 1);
    add(0, 4'b0000, 1, 0, 0, 1);
    add(0, 4'b0000, 2, 0, 0, 1);
    add(0, 4'b0000, 3, 0, 0, 4);
    add(0, 4'b0000, 4, 0, 0, 2);
    add(0, 4'b0000, 5, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 0, 5);
    // N-S button in MG: walk for first two SG cycles
    add(0, 4'b0010, 0, 0, 0, 1);
    add(0, 4'b0000, 1, 0, 0, 2);
    add(0, 4'b0000, 2, 0, 0, 1);
    add(0, 4'b0000, 3, 1, 0, 2);
    add(0, 4'b0000, 3, 0, 0, 2);
    add(0, 4'b0000, 4, 0, 0, 2);
    add(0, 4'b0000, 5, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 0, 4);
    // W-E button in SG served at next MG; button mid-MG deferred one more MG
    add(1, 4'b0000, 1, 0, 0, 1);
    add(0, 4'b0000, 1, 0, 0, 1);
    add(0, 4'b0000, 2, 0, 0, 1);
    add(0, 4'b0000, 3, 0, 0, 1);
    add(0, 4'b0001, 3, 0, 0, 1);
    add(0, 4'b0000, 3, 0, 0, 2);
    add(0, 4'b0000, 4, 0, 0, 2);
    add(0, 4'b0000, 5, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 1, 2);
    add(0, 4'b0001, 0, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 0, 1);
    add(1, 4'b0000, 1, 0, 0, 1);
    add(0, 4'b0000, 1, 0, 0, 1);
    add(0, 4'b0000, 2, 0, 0, 1);
    add(0, 4'b0000, 3, 0, 0, 4);
    add(0, 4'b0000, 4, 0, 0, 2);
    add(0, 4'b0000, 5, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 1, 2);
    add(0, 4'b0000, 0, 0, 0, 1);
    // continuous side demand: max-green force-off, then min-green main
    add(1, 4'b0000, 0, 0, 0, 1);
    add(1, 4'b0000, 1, 0, 0, 2);
    add(1, 4'b0000, 2, 0, 0, 1);
    add(1, 4'b0000, 3, 0, 0, 8);
    add(1, 4'b0000, 4, 0, 0, 2);
    add(1, 4'b0000, 5, 0, 0, 1);
    add(1, 4'b0000, 0, 0, 0, 4);
    add(1, 4'b0000, 1, 0, 0, 1);
  endtask

  initial begin
    bit found;
    rst_62 = 1'b1; tick_62 = 1'b1; i1_62 = 1'b0; i2_62 = 1'b0;
    b1_62 = 1'b0; b2_62 = 1'b0; b3_62 = 1'b0; b4_62 = 1'b0;
    build_table();

    #1;
    check_outputs("reset", exp_word(3'd0, 1'b0, 1'b0));
    #21 rst_62 = 1'b0;

    // idle: main green rests indefinitely
    for (int c = 0; c < 50; c++) begin
      step();
      check_outputs($sformatf("idle%0d", c), exp_word(3'd0, 1'b0, 1'b0));
    end

    // scoreboard pass over the vector table
    foreach (tbl[n]) begin
      i2_62 = tbl[n].i2;
      {b4_62, b3_62, b2_62, b1_62} = tbl[n].b;
      exp_q.push_back(exp_word(tbl[n].ph, tbl[n].wns, tbl[n].wew));
      step();
      check_outputs($sformatf("vec%0d", n), exp_q.pop_front());
    end
    b1_62 = 1'b0; b2_62 = 1'b0; b3_62 = 1'b0; b4_62 = 1'b0;

    // side demand still held: run into SY, then reset asynchronously mid-cycle
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (phase_62 == 3'd4) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reach_sy: phase stuck at %0d, wanted 4 within 40 cycles", phase_62);
    end
    #2;
    i2_62 = 1'b0;
    rst_62 = 1'b1;
    #1;
    check_outputs("async_rst", exp_word(3'd0, 1'b0, 1'b0));
    #4 rst_62 = 1'b0;

    // latched side request must have been discarded
    for (int c = 0; c < 10; c++) begin
      step();
      check_outputs($sformatf("post_rst%0d", c), exp_word(3'd0, 1'b0, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_phase_scheduler.md
Name: tl_phase_scheduler

Overview:
Timed phase scheduler for the two-street intersection with pedestrian crosswalks. It latches car-sensor and crosswalk-button requests and sequences six light phases: main green, main yellow, all-red, side green, side yellow, all-red. All phases are timed in units of an external tick. It drives the main/side lamp and walk outputs directly, replacing untimed per-clock phase stepping with minimum/maximum green, yellow and clearance intervals.

Parameters:
MIN_GREEN, 8, minimum green dwell in ticks (>=1)
MAX_GREEN, 30, side-green force-off limit in ticks (>=MIN_GREEN)
YELLOW, 3, yellow dwell in ticks (>=1)
ALL_RED, 1, all-red clearance in ticks (>=1)
WALK, 5, walk-light duration in ticks (1..MIN_GREEN)
CW, 6, timer width; 2^CW-1 >= MAX_GREEN

Ports:
clk_62  in  1  clock
rst_62  in  1  reset, asynchronous, active-high
tick_62  in  1  one-cycle timing strobe; all timers advance only when high
i1_62  in  1  main-street car present (level)
i2_62  in  1  side-street car present (level)
b1_62, b2_62, b3_62, b4_62  in  1 each  crosswalk buttons; b1/b3 = west-east, b2/b4 = north-south
r1_62, y1_62, g1_62  out  1 each  main-street lamps
r2_62, y2_62, g2_62  out  1 each  side-street lamps
w1_62, w3_62  out  1 each  north-south walk
w2_62, w4_62  out  1 each  west-east walk
phase_62  out  3  current state encoding

Behaviour:
- Reset (async, rst_62=1): state MG; timer=0; all request latches=0; walk flags=0; g1=1, r2=1, all other lamps and walk outputs 0; phase_62=0.
- State encoding: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5. Codes 6/7 are illegal and return to AR2 on the next clock.
- Timer: cleared to 0 on every state change. Otherwise +1 on each clk with tick_62=1. Saturates at 2^CW-1.
- Fixed-length states last exactly N ticks: exit on the clock where tick_62=1 and timer==N-1.
  MY: N=YELLOW, goes to AR1. AR1: N=ALL_RED, goes to SG. SY: N=YELLOW, goes to AR2. AR2: N=ALL_RED, goes to MG.
- Request latches, sticky: side_req set by i2; ns_ped set by b2|b4; ew_ped set by b1|b3.
- On entry to SG: side_req and ns_ped clear, and walk_ns is loaded with the old ns_ped.
- On entry to MG: ew_ped clears, and walk_ew is loaded with the old ew_ped.
- A set in the same cycle as a clear wins; the request stays latched.
- MG exit: tick_62=1, timer>=MIN_GREEN-1, and (side_req|ns_ped|i2) goes to MY. With no demand, MG holds indefinitely; main is the rest phase.
- SG exit: tick_62=1, timer>=MIN_GREEN-1, and (i2==0 | timer>=MAX_GREEN-1) goes to SY. Side always returns to main, so an unanswered ew_ped or i1 cannot starve.
- Lamps, Moore-decoded from state only:
  MG: g1, r2. MY: y1, r2. AR1 and AR2: r1, r2. SG: r1, g2. SY: r1, y2.
  Exactly one lamp per street is high in every state.
- Walk: w2/w4 = walk_ew & (state==MG) & (timer<WALK). w1/w3 = walk_ns & (state==SG) & (timer<WALK).
  Walk is never high outside a green of the crossing-compatible street, and never simultaneously N-S and W-E.
- Buttons pressed mid-green after entry are latched and served on the next entry to that green, not the current one.
- tick_62 low freezes timers and state. Requests still latch.
- phase_62 equals the state register.
- Reset mid-phase: immediate return to the MG reset outputs, with pending requests discarded.

Test Plan:
Bench parameters: MIN_GREEN=4, MAX_GREEN=8, YELLOW=2, ALL_RED=1, WALK=2, tick_62=1 every cycle.
1. Reset, no inputs for 50 cycles -> g1=1, r2=1 throughout; phase_62=0; all walk outputs 0.
2. Pulse i2 for 1 cycle at cycle 10 (MG timer already >=3) -> MY for 2 cycles, AR1 for 1, SG entered. With i2=0, SG lasts exactly 4 cycles, then SY 2, AR2 1, MG.
3. Hold i2=1 continuously -> SG lasts exactly 8 cycles (max-green force-off), then SY. After MG min-green of 4 cycles, the cycle repeats.
4. Pulse b2 during MG -> side phase occurs; w1=w3=1 for exactly the first 2 SG cycles, then 0; w2/w4 stay 0.
5. Pulse b1 during SG -> w2=w4=1 for the first 2 cycles of the next MG. Pulse b1 again mid-MG -> no walk until the following MG.
6. Assert rst_62 mid-SY, asynchronous to clk -> outputs immediately g1=1, r2=1, walks 0, phase_62=0. A latched side_req is discarded: MG holds.
